// File: rtl/uart_tx_top.sv
// UART transmitter: start, 5-8 data bits LSB-first, optional parity, 1/1.5/2 stop bits at 16x oversampling.
// Optional line break forcing is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_top (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic       set_break,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       pop,
   output logic       tx,
   output logic       temt
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] wls_q;
   logic       stb_q, pen_q;
   logic [7:0] sr_q, sr_d;
   logic       par_q, par_d;
   logic       load, shift;
   logic       tx_q, tx_d, pop_d;

   function automatic logic [7:0] mask_word(input logic [7:0] d, input logic [1:0] w);
      case (w)
         2'b00:   return {3'b000, d[4:0]};
         2'b01:   return {2'b00, d[5:0]};
         2'b10:   return {1'b0, d[6:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] w,
                                       input logic e, input logic s);
      logic [7:0] m;
      m = mask_word(d, w);
      case ({s, e})
         2'b00:   return ~^m;
         2'b01:   return ^m;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Stop length minus one: 1, 2, or 1.5 bits (the last only for 5-bit words)
   function automatic logic [4:0] stop_load(input logic [1:0] w, input logic s);
      if (!s)            return 5'd15;
      else if (w == 2'b00) return 5'd23;
      else               return 5'd31;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      load    = 1'b0;
      shift   = 1'b0;
      pop_d   = 1'b0;
      if (baud_pulse) begin
         case (state_q)
            S_IDLE: begin
               if (tx_valid) begin
                  load    = 1'b1;
                  pop_d   = 1'b1;
                  cnt_d   = 5'd15;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (cnt_q == 5'd0) begin
                  cnt_d   = 5'd15;
                  bit_d   = 3'd4 + {1'b0, wls_q};
                  state_d = S_DATA;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_DATA: begin
               if (cnt_q == 5'd0) begin
                  shift = 1'b1;
                  cnt_d = 5'd15;
                  if (bit_q == 3'd0) begin
                     if (pen_q) begin
                        state_d = S_PARITY;
                     end else begin
                        cnt_d   = stop_load(wls_q, stb_q);
                        state_d = S_STOP;
                     end
                  end else begin
                     bit_d = bit_q - 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_PARITY: begin
               if (cnt_q == 5'd0) begin
                  cnt_d   = stop_load(wls_q, stb_q);
                  state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_STOP: begin
               if (cnt_q == 5'd0) begin
                  if (tx_valid) begin
                     load    = 1'b1;
                     pop_d   = 1'b1;
                     cnt_d   = 5'd15;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // The line value is derived from the upcoming state so tx is a clean register output
   always_comb begin
      sr_d  = sr_q;
      par_d = par_q;
      if (load) begin
         sr_d  = tx_data;
         par_d = parity_bit(tx_data, wls, eps, sticky_parity);
      end else if (shift) begin
         sr_d = {1'b0, sr_q[7:1]};
      end
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = sr_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         bit_q   <= 3'd0;
         wls_q   <= 2'b00;
         stb_q   <= 1'b0;
         pen_q   <= 1'b0;
         tx_q    <= 1'b1;
         pop     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         pop     <= pop_d;
         if (load) begin
            wls_q <= wls;
            stb_q <= stb;
            pen_q <= pen;
         end
      end
   end

   always_ff @(posedge clk) begin
      sr_q  <= sr_d;
      par_q <= par_d;
   end

   assign temt = (state_q == S_IDLE);

`ifdef UART_TX_BREAK_EN
   assign tx = tx_q & ~set_break;
`else
   logic break_unused;
   assign break_unused = set_break;
   assign tx = tx_q;
`endif

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: frame formats, parity modes, back-to-back, async reset, baud gating, break.
module tb_uart_tx_top;

   logic       clk = 1'b0;
   logic       rst, baud_pulse, stb, pen, eps, sticky_parity, set_break, tx_valid;
   logic [1:0] wls;
   logic [7:0] tx_data;
   logic       pop, tx, temt;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_top dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .wls(wls), .stb(stb), .pen(pen),
      .eps(eps), .sticky_parity(sticky_parity), .set_break(set_break), .tx_valid(tx_valid),
      .tx_data(tx_data), .pop(pop), .tx(tx), .temt(temt)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_lcr(input logic [1:0] w, input logic s, input logic p, input logic e,
                          input logic sp);
      wls = w; stb = s; pen = p; eps = e; sticky_parity = sp;
   endtask

   task automatic wait_pop(input string tag);
      int i;
      i = 0;
      @(negedge clk);
      while (pop !== 1'b1 && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_pop_seen"}, pop, 1'b1);
   endtask

   // Starts on the sample right after the popping edge; ends on the last stop-tick sample.
   task automatic frame_check(input string tag, input logic [9:0] bits, input int nbits,
                              input int stop_ticks, input logic brk);
      int total;
      logic e;
      total = nbits * 16 + stop_ticks;
      for (int k = 0; k < total; k++) begin
         if (k > 0) @(negedge clk);
         e = (k < nbits * 16) ? bits[k/16] : 1'b1;
         if (brk) e = 1'b0;
         chk($sformatf("%s_tx_%0d", tag, k), tx, e);
         chk($sformatf("%s_pop_%0d", tag, k), pop, (k == 0));
         chk($sformatf("%s_temt_%0d", tag, k), temt, 1'b0);
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_temt_end"}, temt, 1'b1);
      chk({tag, "_tx_end"}, tx, 1'b1);
      chk({tag, "_pop_end"}, pop, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, cnt, i;
      rst = 1'b0; baud_pulse = 1'b1; set_break = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_pop", pop, 1'b0);
      chk("rst_temt", temt, 1'b1);
      rst = 1'b1;
      @(negedge clk);

      // 8N1 0x55
      tx_data = 8'h55; tx_valid = 1'b1;
      wait_pop("8n1");
      tx_valid = 1'b0;
      frame_check("8n1", {1'b0, 8'h55, 1'b0}, 9, 16, 1'b0);
      idle_check("8n1");

      // 7E1 0x41 (bit7 set but ignored); LCR changed mid-frame must not matter
      set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      tx_data = 8'hC1; tx_valid = 1'b1;
      wait_pop("7e1");
      tx_valid = 1'b0;
      set_lcr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      frame_check("7e1", {1'b0, 1'b0, 7'h41, 1'b0}, 9, 16, 1'b0);
      idle_check("7e1");

      // 7O1 0x41
      set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      tx_data = 8'h41; tx_valid = 1'b1;
      wait_pop("7o1");
      tx_valid = 1'b0;
      frame_check("7o1", {1'b0, 1'b1, 7'h41, 1'b0}, 9, 16, 1'b0);
      idle_check("7o1");

      // 5-bit sticky parity 1, 1.5 stop
      set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      tx_data = 8'h1B; tx_valid = 1'b1;
      wait_pop("stk1");
      tx_valid = 1'b0;
      frame_check("stk1", {3'b000, 1'b1, 5'h1B, 1'b0}, 7, 24, 1'b0);
      idle_check("stk1");

      // 5-bit sticky parity 0, 1.5 stop, upper data bits ignored
      set_lcr(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
      tx_data = 8'hE7; tx_valid = 1'b1;
      wait_pop("stk0");
      tx_valid = 1'b0;
      frame_check("stk0", {3'b000, 1'b0, 5'h07, 1'b0}, 7, 24, 1'b0);
      idle_check("stk0");

      // 6N2
      set_lcr(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      tx_data = 8'hEA; tx_valid = 1'b1;
      wait_pop("6n2");
      tx_valid = 1'b0;
      frame_check("6n2", {3'b000, 6'h2A, 1'b0}, 7, 32, 1'b0);
      idle_check("6n2");

      // Back-to-back 8N1: 0xA3 then 0x0F
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      tx_data = 8'hA3; tx_valid = 1'b1;
      wait_pop("b2b_a");
      t1 = cyc;
      tx_data = 8'h0F;
      frame_check("b2b_a", {1'b0, 8'hA3, 1'b0}, 9, 16, 1'b0);
      @(negedge clk);
      t2 = cyc;
      tx_valid = 1'b0;
      chk32("b2b_pop_gap", t2 - t1, 160);
      frame_check("b2b_b", {1'b0, 8'h0F, 1'b0}, 9, 16, 1'b0);
      idle_check("b2b");

      // Async reset during data bit 3
      tx_data = 8'h55; tx_valid = 1'b1;
      wait_pop("rstmid");
      tx_valid = 1'b0;
      repeat (70) @(negedge clk);
      chk("rstmid_bit3", tx, 1'b0);
      chk("rstmid_busy", temt, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_tx", tx, 1'b1);
      chk("rstmid_temt", temt, 1'b1);
      chk("rstmid_pop", pop, 1'b0);
      @(negedge clk);
      chk("rstmid_hold_tx", tx, 1'b1);
      rst = 1'b1;
      tx_data = 8'h0F; tx_valid = 1'b1;
      wait_pop("rstnext");
      tx_valid = 1'b0;
      frame_check("rstnext", {1'b0, 8'h0F, 1'b0}, 9, 16, 1'b0);
      idle_check("rstnext");

      // Baud gating: no pop without a tick, start bit spans 16 ticks every 4 clocks
      baud_pulse = 1'b0;
      set_lcr(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tx_data = 8'h01; tx_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("slow_nopop", pop, 1'b0);
         chk("slow_idle", temt, 1'b1);
      end
      baud_pulse = 1'b1;
      @(negedge clk);
      chk("slow_pop", pop, 1'b1);
      tx_valid = 1'b0;
      cnt = 0;
      while (tx === 1'b0 && cnt < 200) begin
         cnt++;
         baud_pulse = ((cnt % 4) == 0);
         @(negedge clk);
      end
      chk32("slow_start_len", cnt, 64);
      baud_pulse = 1'b1;
      i = 0;
      while (temt !== 1'b1 && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("slow_done", temt, 1'b1);

      // Break during a frame
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      set_break = 1'b1;
      tx_data = 8'h55; tx_valid = 1'b1;
      wait_pop("brk");
      tx_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
      frame_check("brk", {1'b0, 8'h55, 1'b0}, 9, 16, 1'b1);
`else
      frame_check("brk", {1'b0, 8'h55, 1'b0}, 9, 16, 1'b0);
`endif
      set_break = 1'b0;
      idle_check("brk");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Serial transmitter for the UART block, mirroring the receive path on the line side. Takes parallel characters from the TX holding FIFO via a pop handshake, then serialises each as start, 5–8 data bits LSB-first, optional parity, and 1/1.5/2 stop bits. Timing comes from the shared 16× oversampling `baud_pulse`. Line control (LCR) fields are inputs, sampled once per frame, so LCR writes never corrupt a frame in flight.

## Interface
- No parameters; oversampling is fixed at 16 baud_pulse ticks per bit.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `baud_pulse` in 1: one-`clk`-wide tick at 16× the baud rate.
- `wls` in 2: word length; 00=5, 01=6, 10=7, 11=8 data bits.
- `stb` in 1: stop bits; 0 gives 1, 1 gives 2 (1.5 when `wls`=00).
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sticky_parity` in 1: stick parity.
- `set_break` in 1: force the line low (see Configuration).
- `tx_valid` in 1: FIFO not empty; `tx_data` is valid.
- `tx_data` in 8: character at the FIFO head; bits above the word length are ignored.
- `pop` out 1: one-`clk` pulse, the character was consumed.
- `tx` out 1: serial line, idle high.
- `temt` out 1: transmitter empty, meaning no frame in progress.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP. Each bit is held for 16 baud_pulse ticks using a 5-bit down-counter.
- **IDLE:**
  - On a `baud_pulse` with `tx_valid`=1: latch `tx_data`, `wls`, `stb`, `pen`, `eps`, `sticky_parity`.
  - Pulse `pop`, drive `tx`=0, load count=15, go to START.
- **START:** at count 0, load count=15 and bit counter=4+`wls`, go to DATA.
- **DATA:**
  - `tx` = shift_reg[0]. At count 0, shift right.
  - At bit counter 0 and count 0, go to PARITY if `pen`, otherwise STOP.
  - Otherwise decrement the bit counter.
- **PARITY:** `tx` = parity bit, held 16 ticks, then go to STOP. The parity bit is computed from the latched data masked to the word length:
  - {`sticky_parity`,`eps`}=00: odd, i.e. ~^data.
  - 01: even, i.e. ^data.
  - 10: constant 1.
  - 11: constant 0.
- **STOP:**
  - `tx`=1; stop length is 16, 32, or 24 ticks (the 24-tick case is `wls`=00 with `stb`=1).
  - On the final tick with `tx_valid`=1: latch the next character, pulse `pop`, drive `tx`=0, go to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- **`temt`:** 1 in IDLE, 0 in every other state.
- **Changes between `baud_pulse` ticks:**
  - `tx_valid` or LCR changes have no effect.
  - LCR changes mid-frame affect only the next frame.
- **`tx_data` stability:** `tx_data` must be stable in the cycle `pop` is asserted. It is not sampled afterwards.

## Timing
- **Reset values:** `tx`=1, `pop`=0, `temt`=1, state=IDLE, all counters 0. Reset takes effect asynchronously, including mid-frame: `tx` returns high immediately and any partial character is discarded with no re-pop.
- **Outputs:** `tx` and `pop` are registered. `tx` falls on the same `clk` edge that pops, i.e. the edge after the qualifying `baud_pulse` is sampled.
- **Frame length:** 16×(1 + N + P) + stop ticks, where N is 5–8 data bits and P is 1 if `pen` else 0.
  - 8N1 is exactly 160 baud_pulse ticks.
  - 5-bit, no parity, 1.5 stop is 120 ticks.
- **Pop count:** `pop` is asserted exactly once per frame and never in two consecutive cycles.
- **`baud_pulse` stuck high:** the block advances one tick per `clk`. This is legal and is used for fast simulation.

## Configuration
- **`UART_TX_BREAK_EN` defined:**
  - While `set_break`=1, `tx` is forced to 0 combinationally after the register, in any state.
  - The FSM keeps running, so a frame in progress completes invisibly and still pops.
  - When `set_break` is released, `tx` resumes FSM value.
- **`UART_TX_BREAK_EN` undefined:** the `set_break` port still exists but is ignored, and `tx` always reflects the FSM.

## Test plan
- **8N1, 0x55:** `wls`=11, `pen`=0, `baud_pulse` each cycle → `tx` 0,1,0,1,0,1,0,1,0,1 each held 16 cycles, then high. One `pop`. `temt` returns to 1 after 160 cycles.
- **7E1, 0x41:** `wls`=10, `pen`=1, `eps`=1 → data bits 1000001, parity 0; frame 160 ticks. Then repeat with `eps`=0 → parity 1.
- **Sticky parity:** 5-bit, `pen`=1, {`sticky_parity`,`eps`}=10 then 11 → parity bit constant 1 then 0, regardless of data. `stb`=1 → stop high for 24 ticks.
- **Back-to-back:** `tx_valid` held with 0xA3 then 0x0F, 8N1 → second start bit immediately follows the 16th stop tick. Two `pop` pulses exactly 160 ticks apart.
- **Reset mid-frame:** assert `rst` low during DATA bit 3 → `tx`=1 and `temt`=1 asynchronously. After release with `tx_valid`=1, the next frame starts cleanly.
- **Break (with `UART_TX_BREAK_EN`):** `set_break`=1 during a frame → `tx`=0 throughout and the frame still pops. With the macro undefined, the same stimulus gives a normal waveform.
